vstream_rx_fifo: RTL
====================

# vstream_rx_fifo

Synthesizable receiver for the codebase's sync-timed 8-bit video stream (vsync/hsync/valid/data, no back-pressure). It sits at the output of a processing stage such as region binarization. It converts the stream into a ready/valid pixel stream with start-of-frame and end-of-line markers, buffering it in an internal FIFO so a throttled consumer can drain it. It also measures the frame resolution and flags pixels lost to overflow.

## Interface
- DATA_WIDTH, 8, pixel width
- FIFO_DEPTH, 1024, FIFO entries; power of two, ≥4
- RES_W, 16, width of resolution counters/outputs
- clk  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- vin_vsync  in  1  frame sync, active high; rising edge = new frame
- vin_hsync  in  1  line sync; ignored (line ends derived from vin_valid)
- vin_valid  in  1  active pixel qualifier
- vin_data  in  DATA_WIDTH  pixel, sampled when vin_valid=1
- vout_data  out  DATA_WIDTH  pixel at FIFO head
- vout_sof  out  1  head pixel is first pixel of a frame
- vout_eol  out  1  head pixel is last pixel of a line
- vout_valid  out  1  FIFO head valid
- vout_ready  in  1  consumer accepts; transfer when vout_valid & vout_ready
- frame_xres  out  RES_W  pixels per line of last completed frame
- frame_yres  out  RES_W  lines of last completed frame
- res_valid  out  1  frame_xres/yres hold a measured frame
- overflow  out  1  sticky: a pixel was dropped this frame
- frame_done  out  1  one-cycle pulse at each vsync rising edge after the first

## Operation
- vsync edge detect: register vin_vsync; rise = vin_vsync & ~vsync_d.
- Stage s1: every cycle, s1_vld<=vin_valid, s1_dat<=vin_data. When s1_vld=1, write {sof_pend, eol, s1_dat} to FIFO, eol = ~vin_valid (current cycle) | rise.
- sof_pend: set on rise; cleared by the first s1 write (that entry carries sof=1). Never set before the first rise after reset: pixels before the first vsync are written with sof=0.
- Counters: x_cnt increments per s1 write, clears after an eol write. y_cnt increments per eol write. On the first eol of a frame (y_cnt=0), latch x_cnt+1 into x_first.
- On rise (not the first after reset): frame_xres<=x_first, frame_yres<=y_cnt (+1 if an eol is written the same cycle), res_valid<=1, frame_done pulse. Then y_cnt, x_cnt, x_first clear. The first rise only arms.
- Counters saturate at 2^RES_W-1.
- FIFO: synchronous, first-word-fall-through with registered output. vout_* reflect the head; pop on vout_valid & vout_ready. Write when full: entry dropped, overflow<=1. Counters still advance so the resolution stays correct.
- overflow clears on rise unless a drop occurs in the same cycle; a same-cycle drop keeps it 1.
- Simultaneous write and pop at full: the pop frees space and the write succeeds.
- Reset: all outputs, counters, flags and FIFO pointers are 0. vout_valid=0, overflow=0, res_valid=0.

## Timing
- Pixel on vin at edge T -> in s1 after T+1 -> FIFO write at T+2 -> vout_valid=1 after T+3 (FIFO empty). Latency is 3 cycles.
- Full throughput: one write and one pop per cycle sustained. No combinational path from vout_ready to vout_valid or vout_data.
- frame_xres/yres/res_valid update and frame_done pulse 1 cycle after the vin_vsync rising sample.
- rise while vin_valid stays high: the pixel in s1 is tagged eol and the partial line is counted.
- rst_n asserted mid-frame: immediate clear and FIFO content discarded. Before the next vsync, behaviour is the same as after the first reset.

## Test plan
- 4x2 frame (data 1..8), vout_ready=1, two vsyncs -> 8 outputs in order; sof only on 1; eol on 4 and 8; vout_valid 3 cycles after pixel 1. Second rise -> frame_xres=4, frame_yres=2, res_valid=1, one frame_done pulse.
- 800x600 timing from the codebase parameters, vout_ready random 50% -> with FIFO_DEPTH=1024, overflow=1 and frame_xres=800, frame_yres=600. With vout_ready=1: overflow=0 and 480000 pixels output.
- FIFO_DEPTH=4, vout_ready=0, 6-pixel line -> first 4 stored, overflow=1. Next rise with no drop -> overflow=0; vout_ready=1 then yields exactly 4 pixels.
- Pixels before the first vsync -> output with sof=0, res_valid stays 0. First rise: no frame_done.
- Reset pulse mid-line with FIFO holding 3 entries -> vout_valid=0 next cycle, frame_xres=0, no stale data emitted afterwards.
- Full FIFO with vout_ready=1 and a write in the same cycle -> no drop, overflow stays 0, count stays at FIFO_DEPTH.

Source files
------------

// File: rtl/vstream_rx_fifo.sv
// rtl/vstream_rx_fifo.sv - sync-timed video to ready/valid pixel stream with FIFO, resolution meter and overflow flag
module vstream_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 1024,
    parameter int RES_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vin_vsync,
    input  logic                  vin_hsync,
    input  logic                  vin_valid,
    input  logic [DATA_WIDTH-1:0] vin_data,
    output logic [DATA_WIDTH-1:0] vout_data,
    output logic                  vout_sof,
    output logic                  vout_eol,
    output logic                  vout_valid,
    input  logic                  vout_ready,
    output logic [RES_W-1:0]      frame_xres,
    output logic [RES_W-1:0]      frame_yres,
    output logic                  res_valid,
    output logic                  overflow,
    output logic                  frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 2;
    localparam logic [AW:0]      DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [RES_W-1:0] RES_MAX = '1;

    function automatic logic [RES_W-1:0] sat_inc(input logic [RES_W-1:0] v);
        return (v == RES_MAX) ? v : v + 1'b1;
    endfunction

    logic unused_hsync;
    assign unused_hsync = vin_hsync;

    logic                  vsync_q, armed_q, sof_pend_q;
    logic                  s1_vld_q;
    logic [DATA_WIDTH-1:0] s1_dat_q;
    logic [RES_W-1:0]      x_cnt_q, y_cnt_q, x_first_q;
    logic [RES_W-1:0]      x_cnt_d, y_cnt_d, x_first_d;
    logic [RES_W-1:0]      meas_x, meas_y;
    logic [RES_W-1:0]      frame_xres_q, frame_yres_q;
    logic                  res_valid_q, overflow_q, frame_done_q;

    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           mem_cnt_q, mem_cnt_d, total;
    logic                  out_valid_q;
    logic [EW-1:0]         out_q;

    logic rise, eol, wr_req, pop, full, wr_en, drop, load;
    logic [EW-1:0] entry;

    assign rise   = vin_vsync & ~vsync_q;
    assign wr_req = s1_vld_q;
    assign eol    = ~vin_valid | rise;
    assign entry  = {sof_pend_q, eol, s1_dat_q};

    // Occupancy includes the output register so capacity is exactly FIFO_DEPTH.
    assign pop   = out_valid_q & vout_ready;
    assign total = mem_cnt_q + {{AW{1'b0}}, out_valid_q};
    assign full  = (total == DEPTH_C);
    assign wr_en = wr_req & (~full | pop);
    assign drop  = wr_req & full & ~pop;
    assign load  = (mem_cnt_q != '0) & (~out_valid_q | pop);
    assign mem_cnt_d = mem_cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, load};

    always_comb begin
        x_cnt_d   = x_cnt_q;
        y_cnt_d   = y_cnt_q;
        x_first_d = x_first_q;
        if (wr_req) begin
            if (eol) begin
                x_cnt_d = '0;
                y_cnt_d = sat_inc(y_cnt_q);
                if (y_cnt_q == '0) x_first_d = sat_inc(x_cnt_q);
            end else begin
                x_cnt_d = sat_inc(x_cnt_q);
            end
        end
        // Measurement includes a line closed by the same-cycle eol write.
        meas_x = x_first_d;
        meas_y = y_cnt_d;
        if (rise) begin
            x_cnt_d   = '0;
            y_cnt_d   = '0;
            x_first_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            armed_q      <= 1'b0;
            sof_pend_q   <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_dat_q     <= '0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            x_first_q    <= '0;
            frame_xres_q <= '0;
            frame_yres_q <= '0;
            res_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            vsync_q      <= vin_vsync;
            armed_q      <= armed_q | rise;
            s1_vld_q     <= vin_valid;
            s1_dat_q     <= vin_data;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            x_first_q    <= x_first_d;
            frame_done_q <= rise & armed_q;
            if (rise) sof_pend_q <= 1'b1;
            else if (wr_req) sof_pend_q <= 1'b0;
            if (drop) overflow_q <= 1'b1;
            else if (rise) overflow_q <= 1'b0;
            if (rise && armed_q) begin
                frame_xres_q <= meas_x;
                frame_yres_q <= meas_y;
                res_valid_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            mem_cnt_q <= mem_cnt_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (load) begin
                out_q       <= mem[rd_ptr_q];
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                out_valid_q <= 1'b1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign vout_data  = out_q[DATA_WIDTH-1:0];
    assign vout_eol   = out_q[EW-2];
    assign vout_sof   = out_q[EW-1];
    assign vout_valid = out_valid_q;
    assign frame_xres = frame_xres_q;
    assign frame_yres = frame_yres_q;
    assign res_valid  = res_valid_q;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;
endmodule
